// File: rtl/vram_pkg.sv
// Shared VRAM sizing and writer state encoding, common to the spectrum
// writer and the VGA generator's VRAM.
package vram_pkg;

    localparam int WORD_SIZE_DEF  = 16;
    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DEPTH          = 1 << ADDR_WIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        WRITE = 3'd2,
        FILL  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a delay flop; pulses 'fall' for one
// clock when the synchronized input goes 1 -> 0. All flops reset to 1 so a
// released reset never produces a spurious edge on an idle-high line.
module sync_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronizer chain plus one delay stage for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign fall = prev & ~sync;

endmodule

// File: rtl/vram_spectrum_writer.sv
// Streams signed samples into VRAM as clamped magnitudes, one frame of
// DEPTH words per video frame, starting on the VGA vsync falling edge.
//
// Input handshake: a sample transfers on a rising clock edge where
// in_valid and in_ready are both 1. in_ready depends only on the current
// state (never on in_valid); the source must hold in_data/in_last stable
// while in_valid is high and in_ready is low.
module vram_spectrum_writer
    import vram_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RSHIFT     = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  vsync,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_SIZE-1:0]  in_data,
    input  logic                  in_last,
    output logic                  vram_we,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [WORD_SIZE-1:0]  vram_data,
    output logic                  frame_done,
    output logic                  overrun,
    output state_t                dbg_state
);

    // All-ones address is the terminal count DEPTH-1 for any ADDR_WIDTH
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [WORD_SIZE:0]    MAG_MAX   = (WORD_SIZE+1)'((1 << (WORD_SIZE-1)) - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  vs_fall;

    logic                  wr;
    logic [WORD_SIZE-1:0]  wr_data;
    logic                  cnt_clr;
    logic                  cnt_inc;
    logic                  set_ovr;

    logic signed [WORD_SIZE:0] sample_ext;
    logic [WORD_SIZE:0]        mag_full;
    logic [WORD_SIZE-1:0]      mag_clamped;
    logic [WORD_SIZE-1:0]      mag_out;

    sync_edge_detect u_vsync (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (vsync),
        .fall    (vs_fall)
    );

    // One extra bit so negating the most-negative sample cannot overflow;
    // that single case is then clamped back into the positive word range.
    assign sample_ext  = {in_data[WORD_SIZE-1], in_data};
    assign mag_full    = in_data[WORD_SIZE-1] ? -sample_ext : sample_ext;
    assign mag_clamped = (mag_full > MAG_MAX) ? MAG_MAX[WORD_SIZE-1:0] : mag_full[WORD_SIZE-1:0];
    assign mag_out     = mag_clamped >> RSHIFT;

    assign dbg_state = state;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and write-request decode
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        frame_done = 1'b0;
        wr         = 1'b0;
        wr_data    = mag_out;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        set_ovr    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = ARMED;
            end
            ARMED: begin
                if (vs_fall) begin
                    state_next = WRITE;
                    cnt_clr    = 1'b1;
                end
            end
            WRITE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr = 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state_next = in_last ? DONE : DRAIN;
                    end else begin
                        cnt_inc = 1'b1;
                        if (in_last) state_next = FILL;
                    end
                end
            end
            FILL: begin
                wr      = 1'b1;
                wr_data = '0;
                if (cnt == LAST_ADDR) state_next = DONE;
                else                  cnt_inc    = 1'b1;
            end
            DRAIN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    set_ovr = 1'b1;
                    if (in_last) state_next = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = enable ? ARMED : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address counter: cleared at frame start, advanced per write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered VRAM write port; addr/data hold between writes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
        end else begin
            vram_we <= wr;
            if (wr) begin
                vram_addr <= cnt;
                vram_data <= wr_data;
            end
        end
    end

    // Sticky overrun flag, cleared only by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (set_ovr) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_spectrum_writer.sv
// Directed bench for vram_spectrum_writer: full, short, clamped, overrun
// and reset-interrupted frames checked against an expected-write queue.
module tb_vram_spectrum_writer;
    import vram_pkg::*;

    typedef struct packed {
        logic [31:0] stamp;
        logic [9:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        vsync = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;

    logic        in_ready, vram_we, frame_done, overrun;
    logic [9:0]  vram_addr;
    logic [15:0] vram_data;
    state_t      st;

    logic        in_ready4, vram_we4, frame_done4, overrun4;
    logic [9:0]  vram_addr4;
    logic [15:0] vram_data4;
    state_t      st4;

    int          n_vec = 0;
    int          n_err = 0;
    int          ncyc = 0;
    int          done_cnt = 0;
    int          done_stamp = -1;
    int          we_cnt = 0;
    int          last_stamp = 0;
    logic [9:0]  exp_addr = '0;
    exp_t        exp_q[$];
    logic [15:0] got4_q[$];
    logic [15:0] mem [0:1023];

    vram_spectrum_writer #(.WORD_SIZE(16), .ADDR_WIDTH(10), .RSHIFT(0)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .vsync(vsync),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
        .frame_done(frame_done), .overrun(overrun), .dbg_state(st)
    );

    vram_spectrum_writer #(.WORD_SIZE(16), .ADDR_WIDTH(10), .RSHIFT(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .vsync(vsync),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_last(in_last),
        .vram_we(vram_we4), .vram_addr(vram_addr4), .vram_data(vram_data4),
        .frame_done(frame_done4), .overrun(overrun4), .dbg_state(st4)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_mag(input logic [15:0] d, input int sh);
        int v;
        v = $signed(d);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return 16'(v >> sh);
    endfunction

    // scoreboard / monitor on the falling edge
    always @(negedge clock) begin
        exp_t e;
        if (vram_we) begin
            we_cnt++;
            mem[vram_addr] = vram_data;
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(vram_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(vram_addr), 32'(e.addr));
                check("wr_data", 32'(vram_data), 32'(e.data));
                check("wr_lag", ncyc, e.stamp);
            end
        end
        if (frame_done) begin
            done_cnt++;
            done_stamp = ncyc;
        end
        if (vram_we4) got4_q.push_back(vram_data4);
        ncyc++;
    end

    // driver tasks (all called at negedge + 1)
    task automatic send(input logic [15:0] d, input logic l, input bit wr);
        int tries = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && tries < 50) begin
            @(negedge clock); #1;
            tries++;
        end
        if (!in_ready) begin
            check("hs_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        last_stamp = ncyc;
        if (wr) begin
            exp_q.push_back('{stamp: 32'(ncyc), addr: exp_addr, data: exp_mag(d, 0)});
            exp_addr = exp_addr + 10'd1;
        end
        @(negedge clock); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_fill(output int n);
        int start = int'(exp_addr);
        n = 1024 - start;
        for (int a = start; a < 1024; a++)
            exp_q.push_back('{stamp: 32'(last_stamp + 1 + (a - start)), addr: 10'(a), data: 16'h0000});
    endtask

    task automatic arm_frame();
        int tries = 0;
        vsync = 1'b0;
        while (!in_ready && tries < 10) begin
            @(negedge clock); #1;
            tries++;
        end
        if (!in_ready) check("arm_timeout", 0, 1);
        vsync = 1'b1;
        exp_addr = '0;
    endtask

    task automatic finish_frame(input string tag, input int exp_done, input int done_base);
        int tries = 0;
        while (exp_q.size() != 0 && tries < 1200) begin
            @(negedge clock); #1;
            tries++;
        end
        check({tag, "_q_empty"}, exp_q.size(), 0);
        repeat (2) begin @(negedge clock); #1; end
        check({tag, "_done_pulses"}, done_cnt - done_base, 1);
        check({tag, "_done_time"}, done_stamp, exp_done);
        check({tag, "_state_armed"}, 32'(st), 32'(ARMED));
    endtask

    initial begin
        int lat;
        int nfill;
        int base;
        int we_base;
        int rdy_bad;
        logic [15:0] short_v [0:3];

        // reset state
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_we", vram_we, 0);
        check("rst_addr", 32'(vram_addr), 0);
        check("rst_data", 32'(vram_data), 0);
        check("rst_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", 32'(st), 32'(IDLE));
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock); #1;
        check("idle_hold", 32'(st), 32'(IDLE));

        // arm, then measure vsync-fall to in_ready latency with no data
        enable = 1'b1;
        @(negedge clock); #1;
        check("armed", 32'(st), 32'(ARMED));
        check("armed_ready", in_ready, 0);
        vsync = 1'b0;
        lat = 0;
        while (!in_ready && lat < 10) begin
            @(negedge clock); #1;
            lat++;
        end
        check("vsync_latency", lat, 3);
        repeat (4) begin @(negedge clock); #1; end
        vsync = 1'b1;
        repeat (5) begin @(negedge clock); #1; end
        check("stall_no_we", we_cnt, 0);
        check("stall_write", 32'(st), 32'(WRITE));

        // full frame: i-512, last on 1023
        exp_addr = '0;
        base = done_cnt;
        for (int i = 0; i < 1024; i++)
            send(16'(i - 512), i == 1023, 1'b1);
        finish_frame("full", last_stamp, base);
        check("full_addr0", 32'(mem[0]), 32'h0200);
        check("full_addr512", 32'(mem[512]), 32'h0000);
        check("full_addr1023", 32'(mem[1023]), 32'h01FF);
        check("full_overrun", overrun, 0);

        // clamp and shift: dut4 shifts by 4
        arm_frame();
        got4_q.delete();
        base = done_cnt;
        send(16'h8000, 1'b0, 1'b1);
        send(16'h7FFF, 1'b0, 1'b1);
        send(16'hFFFF, 1'b1, 1'b1);
        push_fill(nfill);
        finish_frame("clamp", last_stamp + nfill, base);
        check("shift4_n", got4_q.size(), 1024);
        if (got4_q.size() >= 3) begin
            check("shift4_8000", 32'(got4_q[0]), 32'h07FF);
            check("shift4_7fff", 32'(got4_q[1]), 32'h07FF);
            check("shift4_ffff", 32'(got4_q[2]), 32'h0000);
        end
        check("clamp_addr0", 32'(mem[0]), 32'h7FFF);

        // short frame: 4 samples then zero fill with in_ready low
        short_v[0] = 16'h0005; short_v[1] = 16'hFFF9;
        short_v[2] = 16'h0064; short_v[3] = 16'hFC18;
        arm_frame();
        base = done_cnt;
        for (int i = 0; i < 4; i++)
            send(short_v[i], i == 3, 1'b1);
        push_fill(nfill);
        check("short_nfill", nfill, 1020);
        rdy_bad = 0;
        for (int i = 0; i < 1019; i++) begin
            if (in_ready) rdy_bad++;
            @(negedge clock); #1;
        end
        check("fill_ready_low", rdy_bad, 0);
        finish_frame("short", last_stamp + nfill, base);
        check("short_addr1", 32'(mem[1]), 32'h0007);
        check("short_addr3", 32'(mem[3]), 32'h03E8);
        check("short_addr4", 32'(mem[4]), 32'h0000);
        check("short_addr1023", 32'(mem[1023]), 32'h0000);

        // overrun: 1030 samples, last on the final one
        check("pre_overrun", overrun, 0);
        arm_frame();
        base = done_cnt;
        we_base = we_cnt;
        for (int i = 0; i < 1030; i++)
            send(16'(i - 100), i == 1029, i < 1024);
        finish_frame("ovr", last_stamp, base);
        check("ovr_writes", we_cnt - we_base, 1024);
        check("ovr_flag", overrun, 1);
        check("ovr_addr1023", 32'(mem[1023]), 32'(923));

        // reset mid-frame at sample 300
        arm_frame();
        check("ovr_persist", overrun, 1);
        for (int i = 0; i < 300; i++)
            send(16'(i + 1), 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        reset_n  = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_we", vram_we, 0);
        check("mid_rst_addr", 32'(vram_addr), 0);
        check("mid_rst_data", 32'(vram_data), 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_done", frame_done, 0);
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clock); #1;
        reset_n = 1'b1;
        #1;
        check("post_rst_idle", 32'(st), 32'(IDLE));
        @(negedge clock); #1;
        arm_frame();
        base = done_cnt;
        send(16'h0011, 1'b0, 1'b1);
        send(16'hFFEE, 1'b0, 1'b1);
        send(16'h0033, 1'b1, 1'b1);
        push_fill(nfill);
        finish_frame("post_rst", last_stamp + nfill, base);
        check("post_rst_addr0", 32'(mem[0]), 32'h0011);
        check("post_rst_addr1", 32'(mem[1]), 32'h0012);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // global time limit
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule
